// File: rtl/fridge_pkg.sv
// ---------------------------------------------------------------------------
// fridge_pkg
// Shared definitions for the fridge/freezer cooling scheduler.
//   - FSM state encodings (plain localparams so older tools and waveform
//     viewers see stable numeric codes)
//   - valve zone encodings
//   - temperature code width
//   - demand/satisfaction helpers evaluated one bit wider than the
//     temperature codes, so setpoint + hysteresis never wraps
// ---------------------------------------------------------------------------
package fridge_pkg;

    localparam int TEMP_W  = 5;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_OFF    = 3'd0;
    localparam logic [STATE_W-1:0] ST_REST   = 3'd1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN_FG = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN_FR = 3'd4;

    localparam logic ZONE_FG = 1'b0;
    localparam logic ZONE_FR = 1'b1;

    // Per-cycle cooling request summary for both compartments.
    typedef struct packed {
        logic dem_fg;
        logic dem_fr;
        logic sat_fg;
        logic sat_fr;
    } demand_t;

    // A compartment wants cooling once it is warmer than its setpoint by more
    // than the hysteresis band. The extra MSB keeps setpoint 31 + 2 = 33
    // instead of wrapping to 1, so a maximum setpoint simply never demands.
    function automatic logic is_demand(input logic [TEMP_W-1:0] sense,
                                       input logic [TEMP_W-1:0] set,
                                       input int                hyst);
        logic [TEMP_W:0] limit;
        limit = {1'b0, set} + (TEMP_W + 1)'(hyst);
        return ({1'b0, sense} > limit);
    endfunction

    // A compartment is satisfied once it is at or below its setpoint.
    function automatic logic is_satisfied(input logic [TEMP_W-1:0] sense,
                                          input logic [TEMP_W-1:0] set);
        return (sense <= set);
    endfunction

endpackage

// File: rtl/door_alarm_timer.sv
// ---------------------------------------------------------------------------
// door_alarm_timer
// Counts consecutive cycles a compartment door is open and raises a
// registered alarm once the count reaches DOOR_LIM.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   en     in   timer enable (appliance powered and not in OFF)
//   door   in   1 = door open
//   alarm  out  registered alarm, high while the door has been open for at
//               least DOOR_LIM consecutive enabled cycles
// ---------------------------------------------------------------------------
module door_alarm_timer #(
    parameter int DOOR_LIM = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic door,
    output logic alarm
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(DOOR_LIM);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             alarm_q;
    logic             alarm_d;

    // The open-time counter restarts from zero whenever the door is closed or
    // the timer is disabled, and saturates at the limit so a door left open
    // indefinitely keeps the alarm up without the counter rolling over.
    // The alarm is derived from the next count so it appears on the same edge
    // that the count reaches the limit.
    always_comb begin
        cnt_d   = '0;
        alarm_d = 1'b0;
        if (en && door) begin
            cnt_d   = (cnt_q >= LIM) ? LIM : (cnt_q + ONE);
            alarm_d = (cnt_d >= LIM);
        end
    end

    // Counter and alarm flops, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;

endmodule

// File: rtl/fridge_cooling_scheduler.sv
// ---------------------------------------------------------------------------
// fridge_cooling_scheduler
// Shares one compressor between the fridge and freezer compartments. It
// compares each sensed temperature with its setpoint, picks which compartment
// the compressor cools, enforces minimum on/off times and a maximum run time
// with round-robin fairness, and raises per-door open alarms.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset (priority over i)
//   i           in   appliance power, 1 = on
//   fgt         in   fridge setpoint code (higher = warmer)
//   frt         in   freezer setpoint code
//   fg_sense    in   sensed fridge temperature code
//   fr_sense    in   sensed freezer temperature code
//   door_fg     in   fridge door open
//   door_fr     in   freezer door open
//   comp_on     out  compressor enable (registered)
//   zone_sel    out  valve select, 0 = fridge, 1 = freezer; holds outside RUN
//   state       out  current FSM state code
//   door_alarm  out  bit0 = fridge alarm, bit1 = freezer alarm
// ---------------------------------------------------------------------------
module fridge_cooling_scheduler
    import fridge_pkg::*;
#(
    parameter int HYST     = 2,
    parameter int MIN_ON   = 4,
    parameter int MIN_OFF  = 3,
    parameter int MAX_RUN  = 16,
    parameter int DOOR_LIM = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic [TEMP_W-1:0]  fgt,
    input  logic [TEMP_W-1:0]  frt,
    input  logic [TEMP_W-1:0]  fg_sense,
    input  logic [TEMP_W-1:0]  fr_sense,
    input  logic               door_fg,
    input  logic               door_fr,
    output logic               comp_on,
    output logic               zone_sel,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         door_alarm
);

    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               comp_on_q;
    logic               comp_on_d;
    logic               zone_sel_q;
    logic               zone_sel_d;
    logic               last_served_q;
    logic               last_served_d;
    logic [CNT_W-1:0]   rest_cnt_q;
    logic [CNT_W-1:0]   rest_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q;
    logic [CNT_W-1:0]   run_cnt_d;

    demand_t            dem;
    logic               run_zone;
    logic               sat_self;
    logic               dem_other;
    logic               door_en;
    logic               alarm_fg;
    logic               alarm_fr;

    // Demand and satisfaction come straight from the live inputs every cycle,
    // so sensor or setpoint changes mid-run act immediately.
    always_comb begin
        dem.dem_fg = is_demand(fg_sense, fgt, HYST);
        dem.dem_fr = is_demand(fr_sense, frt, HYST);
        dem.sat_fg = is_satisfied(fg_sense, fgt);
        dem.sat_fr = is_satisfied(fr_sense, frt);
    end

    // While running, look at the compartment being served and at the one
    // waiting; the RUN_FG and RUN_FR states share the same exit rules.
    always_comb begin
        run_zone  = (state_q == ST_RUN_FR) ? ZONE_FR : ZONE_FG;
        sat_self  = (run_zone == ZONE_FR) ? dem.sat_fr : dem.sat_fg;
        dem_other = (run_zone == ZONE_FR) ? dem.dem_fg : dem.dem_fr;
    end

    // Main scheduler FSM.
    // Losing power wins over everything, including minimum on-time, and clears
    // the counters. Coming back from OFF always goes through REST, so the
    // compressor is never restarted straight after a power glitch.
    // A run ends when the served compartment is satisfied after the minimum
    // on-time, or when it has hit the maximum run length while the other
    // compartment is waiting; either way the compressor rests afterwards and
    // the served compartment is remembered for the round-robin tie-break.
    always_comb begin
        state_d       = state_q;
        comp_on_d     = comp_on_q;
        zone_sel_d    = zone_sel_q;
        last_served_d = last_served_q;
        rest_cnt_d    = rest_cnt_q;
        run_cnt_d     = run_cnt_q;

        if (!i) begin
            state_d    = ST_OFF;
            comp_on_d  = 1'b0;
            rest_cnt_d = '0;
            run_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_REST;
                    comp_on_d  = 1'b0;
                    rest_cnt_d = ONE;
                    run_cnt_d  = '0;
                end

                ST_REST: begin
                    comp_on_d = 1'b0;
                    if (rest_cnt_q >= MIN_OFF_C) begin
                        state_d    = ST_IDLE;
                        rest_cnt_d = '0;
                    end else begin
                        rest_cnt_d = rest_cnt_q + ONE;
                    end
                end

                ST_IDLE: begin
                    comp_on_d = 1'b0;
                    if (dem.dem_fg || dem.dem_fr) begin
                        comp_on_d = 1'b1;
                        run_cnt_d = ONE;
                        if (dem.dem_fg && dem.dem_fr) begin
                            // Tie: serve whichever compartment went last.
                            zone_sel_d = (last_served_q == ZONE_FG) ? ZONE_FR : ZONE_FG;
                        end else begin
                            zone_sel_d = dem.dem_fr ? ZONE_FR : ZONE_FG;
                        end
                        state_d = (zone_sel_d == ZONE_FR) ? ST_RUN_FR : ST_RUN_FG;
                    end
                end

                ST_RUN_FG,
                ST_RUN_FR: begin
                    if (((run_cnt_q >= MIN_ON_C) && sat_self) ||
                        ((run_cnt_q == MAX_RUN_C) && dem_other)) begin
                        state_d       = ST_REST;
                        comp_on_d     = 1'b0;
                        rest_cnt_d    = ONE;
                        run_cnt_d     = '0;
                        last_served_d = run_zone;
                    end else begin
                        comp_on_d = 1'b1;
                        run_cnt_d = (run_cnt_q >= MAX_RUN_C) ? MAX_RUN_C : (run_cnt_q + ONE);
                    end
                end

                default: begin
                    // Unused codes recover through OFF and then REST.
                    state_d    = ST_OFF;
                    comp_on_d  = 1'b0;
                    rest_cnt_d = '0;
                    run_cnt_d  = '0;
                end
            endcase
        end
    end

    // FSM state, outputs and counters. last_served starts as freezer so the
    // first contested run after reset goes to the fridge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            comp_on_q     <= 1'b0;
            zone_sel_q    <= ZONE_FG;
            last_served_q <= ZONE_FR;
            rest_cnt_q    <= '0;
            run_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            comp_on_q     <= comp_on_d;
            zone_sel_q    <= zone_sel_d;
            last_served_q <= last_served_d;
            rest_cnt_q    <= rest_cnt_d;
            run_cnt_q     <= run_cnt_d;
        end
    end

    // Door timers only run while powered and out of OFF, which keeps the
    // alarms low in OFF and on the first cycle back from it.
    assign door_en = i && (state_q != ST_OFF);

    door_alarm_timer #(
        .DOOR_LIM (DOOR_LIM),
        .CNT_W    (CNT_W)
    ) u_door_fg (
        .clk   (clk),
        .rst   (rst),
        .en    (door_en),
        .door  (door_fg),
        .alarm (alarm_fg)
    );

    door_alarm_timer #(
        .DOOR_LIM (DOOR_LIM),
        .CNT_W    (CNT_W)
    ) u_door_fr (
        .clk   (clk),
        .rst   (rst),
        .en    (door_en),
        .door  (door_fr),
        .alarm (alarm_fr)
    );

    assign comp_on    = comp_on_q;
    assign zone_sel   = zone_sel_q;
    assign state      = state_q;
    assign door_alarm = {alarm_fr, alarm_fg};

endmodule

// File: tb/tb_fridge_cooling_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fridge_cooling_scheduler
// Directed stimulus with hand-computed per-cycle expectations. The stimulus
// process pushes the expected outputs for each upcoming clock edge into a
// queue; an independent monitor pops one entry after every edge and compares.
// ---------------------------------------------------------------------------
module tb_fridge_cooling_scheduler;
    import fridge_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic [4:0] fgt;
    logic [4:0] frt;
    logic [4:0] fg_sense;
    logic [4:0] fr_sense;
    logic       door_fg;
    logic       door_fr;
    logic       comp_on;
    logic       zone_sel;
    logic [2:0] state;
    logic [1:0] door_alarm;

    typedef struct packed {
        logic [2:0] st;
        logic       comp;
        logic       zone;
        logic [1:0] alarm;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_exp;
    string mon_name;
    int    errors = 0;
    int    checks = 0;

    // 10-time-unit clock.
    always #5 clk = ~clk;

    fridge_cooling_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .i          (i),
        .fgt        (fgt),
        .frt        (frt),
        .fg_sense   (fg_sense),
        .fr_sense   (fr_sense),
        .door_fg    (door_fg),
        .door_fr    (door_fr),
        .comp_on    (comp_on),
        .zone_sel   (zone_sel),
        .state      (state),
        .door_alarm (door_alarm)
    );

    // Holds the current inputs for n edges, queueing the expected outputs
    // seen after each of those edges. Called at a falling edge.
    task automatic applyStimulus(input logic [2:0] st, input logic comp,
                                 input logic zone, input logic [1:0] alarm,
                                 input string name, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.st    = st;
            e.comp  = comp;
            e.zone  = zone;
            e.alarm = alarm;
            exp_q.push_back(e);
            name_q.push_back(name);
            @(negedge clk);
        end
    endtask

    // Compares every output field against one scoreboard entry.
    task automatic checkOutput(input exp_t e, input string name);
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d at %0t", name, state, e.st, $time);
        end
        checks++;
        if (comp_on !== e.comp) begin
            errors++;
            $display("[TB] FAIL %s comp_on: got %0b expected %0b at %0t", name, comp_on, e.comp, $time);
        end
        checks++;
        if (zone_sel !== e.zone) begin
            errors++;
            $display("[TB] FAIL %s zone_sel: got %0b expected %0b at %0t", name, zone_sel, e.zone, $time);
        end
        checks++;
        if (door_alarm !== e.alarm) begin
            errors++;
            $display("[TB] FAIL %s door_alarm: got %b expected %b at %0t", name, door_alarm, e.alarm, $time);
        end
    endtask

    // Monitor: the outputs are registered and valid every cycle, so one
    // expectation is consumed 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                checkOutput(mon_exp, mon_name);
            end
        end
    end

    // Directed scenarios.
    initial begin
        rst      = 1'b1;
        i        = 1'b0;
        fgt      = 5'd5;
        frt      = 5'd10;
        fg_sense = 5'd10;
        fr_sense = 5'd10;
        door_fg  = 1'b0;
        door_fr  = 1'b0;
        $display("[TB] start");

        // Reset, then power-up with fridge demand (10 > 5+2).
        applyStimulus(ST_OFF, 1'b0, 1'b0, 2'b00, "reset", 2);
        rst = 1'b0;
        i   = 1'b1;
        applyStimulus(ST_REST,   1'b0, 1'b0, 2'b00, "pwrup_rest", 3);
        applyStimulus(ST_IDLE,   1'b0, 1'b0, 2'b00, "pwrup_idle", 1);
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "pwrup_run",  1);

        // Satisfied from the second run cycle: still 4 cycles on, then rest.
        fg_sense = 5'd4;
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "minon_hold", 3);
        applyStimulus(ST_REST,   1'b0, 1'b0, 2'b00, "minon_rest", 3);
        applyStimulus(ST_IDLE,   1'b0, 1'b0, 2'b00, "minon_idle", 2);

        // Round robin with both compartments demanding forever.
        rst = 1'b1;
        applyStimulus(ST_OFF, 1'b0, 1'b0, 2'b00, "rr_reset", 1);
        rst      = 1'b0;
        fr_sense = 5'd20;
        frt      = 5'd10;
        fg_sense = 5'd12;
        fgt      = 5'd5;
        applyStimulus(ST_REST,   1'b0, 1'b0, 2'b00, "rr_rest0",  3);
        applyStimulus(ST_IDLE,   1'b0, 1'b0, 2'b00, "rr_idle0",  1);
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "rr_run_fg", 16);
        applyStimulus(ST_REST,   1'b0, 1'b0, 2'b00, "rr_rest1",  3);
        applyStimulus(ST_IDLE,   1'b0, 1'b0, 2'b00, "rr_idle1",  1);
        applyStimulus(ST_RUN_FR, 1'b1, 1'b1, 2'b00, "rr_run_fr", 16);
        applyStimulus(ST_REST,   1'b0, 1'b1, 2'b00, "rr_rest2",  3);
        applyStimulus(ST_IDLE,   1'b0, 1'b1, 2'b00, "rr_idle2",  1);
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "rr_run_fg2", 1);

        // Power loss on run cycle 2, then restore.
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "pl_run2", 1);
        i = 1'b0;
        applyStimulus(ST_OFF, 1'b0, 1'b0, 2'b00, "pl_off", 2);
        i = 1'b1;
        applyStimulus(ST_REST,   1'b0, 1'b0, 2'b00, "pl_rest",  3);
        applyStimulus(ST_IDLE,   1'b0, 1'b0, 2'b00, "pl_idle",  1);
        applyStimulus(ST_RUN_FG, 1'b1, 1'b0, 2'b00, "pl_rerun", 1);

        // Maximum setpoint: 31 > 31+2 is false and must not wrap to 1.
        i        = 1'b0;
        fg_sense = 5'd4;
        frt      = 5'd31;
        fr_sense = 5'd31;
        applyStimulus(ST_OFF, 1'b0, 1'b0, 2'b00, "bnd_off", 1);
        i = 1'b1;
        applyStimulus(ST_REST, 1'b0, 1'b0, 2'b00, "bnd_rest",   3);
        applyStimulus(ST_IDLE, 1'b0, 1'b0, 2'b00, "bnd_no_dem", 6);
        frt      = 5'd0;
        fr_sense = 5'd3;
        applyStimulus(ST_RUN_FR, 1'b1, 1'b1, 2'b00, "bnd_run_fr", 1);
        fr_sense = 5'd0;
        applyStimulus(ST_RUN_FR, 1'b1, 1'b1, 2'b00, "bnd_run_hold", 3);
        applyStimulus(ST_REST,   1'b0, 1'b1, 2'b00, "bnd_rest2",    3);
        applyStimulus(ST_IDLE,   1'b0, 1'b1, 2'b00, "bnd_idle",     1);

        // Door alarms while idling.
        door_fg = 1'b1;
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b00, "door_fg_open",  7);
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b01, "door_fg_alarm", 1);
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b01, "door_fg_hold",  1);
        door_fg = 1'b0;
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b00, "door_fg_clear", 1);
        door_fg = 1'b1;
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b00, "door7_open",  7);
        door_fg = 1'b0;
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b00, "door7_close", 1);
        door_fr = 1'b1;
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b00, "door_fr_open",  7);
        applyStimulus(ST_IDLE, 1'b0, 1'b1, 2'b10, "door_fr_alarm", 1);
        i = 1'b0;
        applyStimulus(ST_OFF,  1'b0, 1'b1, 2'b00, "door_off", 1);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
